// File: rtl/regbank_dump_ctrl.sv
// Debug readout sequencer: walks bank read port 1 over every register and
// streams each word MSB byte first over a valid/ready byte interface.
module regbank_dump_ctrl #(
  parameter int ADDR_BITS = 5,
  parameter int WORD_WIDE = 32,
  parameter int N_REGS    = 1 << ADDR_BITS
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  output logic                 bank_sel_o,
  output logic [ADDR_BITS-1:0] bank_addr_o,
  input  logic [WORD_WIDE-1:0] bank_data_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int BYTES = WORD_WIDE / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SEND,
    NEXT,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [WORD_WIDE-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bank_addr_o = addr_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    bank_sel_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LATCH;
          addr_d  = '0;
        end
      end
      LATCH: begin
        bank_sel_o = 1'b1;
        busy_o     = 1'b1;
        // The word is captured here so later bank writes cannot tear it.
        shift_d    = bank_data_i;
        cnt_d      = '0;
        state_d    = SEND;
      end
      SEND: begin
        bank_sel_o = 1'b1;
        busy_o     = 1'b1;
        tx_valid_o = 1'b1;
        tx_data_o  = shift_q[WORD_WIDE-1 -: 8];
        if (tx_ready_i) begin
          shift_d = shift_q << 8;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BYTE) begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        bank_sel_o = 1'b1;
        busy_o     = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_BITS'(1);
          state_d = LATCH;
        end
      end
      DONE: begin
        // Start is not looked at here, so a request in this cycle is dropped.
        done_o  = 1'b1;
        addr_d  = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_regbank_dump_ctrl.sv
// Self-checking bench for regbank_dump_ctrl: two instances (32 and 4 registers)
// compared every cycle against a byte-queue model of the dump protocol.
module tb_regbank_dump_ctrl;

  localparam int AW = 5;
  localparam int WW = 32;
  localparam int NB = WW / 8;
  localparam int N0 = 32;
  localparam int N1 = 4;

  localparam int M_ONES = 0;
  localparam int M_TOG  = 1;
  localparam int M_RAND = 2;
  localparam int M_ZERO = 3;

  logic          clk = 1'b0;
  logic          rst   [2];
  logic          start [2];
  logic          ready [2];
  logic          sel   [2];
  logic          valid [2];
  logic          busy  [2];
  logic          done  [2];
  logic [AW-1:0] addr  [2];
  logic [WW-1:0] rdata [2];
  logic [7:0]    txd   [2];
  logic [WW-1:0] bank  [2][32];
  int            mode  [2];

  int n_checks = 0;
  int n_errors = 0;
  int test_id  = 0;

  // Reference model: expected byte queue per instance plus protocol timing.
  bit         m_active   [2];
  bit         m_rst_prev [2];
  int         m_cyc      [2];
  int         m_rd       [2];
  int         m_wr       [2];
  int         m_last     [2];
  int         m_due      [2];
  int         n_dones    [2];
  logic [7:0] exp_mem    [2][0:127];

  logic [7:0] lit1 [8] = '{8'hA0, 8'hB0, 8'hC0, 8'h00, 8'hA0, 8'hB0, 8'hC0, 8'h01};
  logic [7:0] lit2 [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

  always #5 clk = ~clk;

  always_comb begin
    rdata[0] = bank[0][addr[0]];
    rdata[1] = bank[1][addr[1]];
  end

  regbank_dump_ctrl #(.ADDR_BITS(AW), .WORD_WIDE(WW), .N_REGS(N0)) dut0 (
    .clock_i    (clk),
    .reset_i    (rst[0]),
    .start_i    (start[0]),
    .bank_sel_o (sel[0]),
    .bank_addr_o(addr[0]),
    .bank_data_i(rdata[0]),
    .tx_data_o  (txd[0]),
    .tx_valid_o (valid[0]),
    .tx_ready_i (ready[0]),
    .busy_o     (busy[0]),
    .done_o     (done[0])
  );

  regbank_dump_ctrl #(.ADDR_BITS(AW), .WORD_WIDE(WW), .N_REGS(N1)) dut1 (
    .clock_i    (clk),
    .reset_i    (rst[1]),
    .start_i    (start[1]),
    .bank_sel_o (sel[1]),
    .bank_addr_o(addr[1]),
    .bank_data_i(rdata[1]),
    .tx_data_o  (txd[1]),
    .tx_valid_o (valid[1]),
    .tx_ready_i (ready[1]),
    .busy_o     (busy[1]),
    .done_o     (done[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs and inputs of the current cycle are both stable
  // at the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int  n;
      bit  drained;
      bit  exp_v;
      n = (k == 0) ? N0 : N1;

      if (m_rst_prev[k]) begin
        check("rst_sel",   sel[k],   1'b0);
        check("rst_addr",  addr[k],  '0);
        check("rst_data",  txd[k],   8'h00);
        check("rst_valid", valid[k], 1'b0);
        check("rst_busy",  busy[k],  1'b0);
        check("rst_done",  done[k],  1'b0);
      end

      if (m_active[k]) begin
        m_cyc[k]++;
        drained = (m_rd[k] == m_wr[k]);
        if (drained && m_cyc[k] > m_last[k] + 2) begin
          n_checks++;
          n_errors++;
          $display("FAIL done_missing: inst %0d got no done at cycle %0d", k, m_last[k] + 2);
          m_active[k] = 1'b0;
        end else if (drained && m_cyc[k] == m_last[k] + 2) begin
          n_dones[k]++;
          check("done_pulse", done[k],  1'b1);
          check("done_busy",  busy[k],  1'b0);
          check("done_sel",   sel[k],   1'b0);
          check("done_valid", valid[k], 1'b0);
          check("done_addr",  addr[k],  n - 1);
          check("done_bytes", m_rd[k],  n * NB);
          if (test_id == 1 && k == 0) check("t1_done_cycle", m_cyc[k], 193);
          if (test_id == 5 && k == 1) check("t5_bytes", m_rd[k], 16);
          m_active[k] = 1'b0;
        end else begin
          exp_v = !drained && (m_cyc[k] >= m_due[k]);
          check("busy",  busy[k],  1'b1);
          check("sel",   sel[k],   1'b1);
          check("done",  done[k],  1'b0);
          check("valid", valid[k], exp_v);
          if (exp_v) begin
            check("data", txd[k], exp_mem[k][m_rd[k]]);
            check("addr", addr[k], m_rd[k] / NB);
            if (ready[k]) begin
              if (test_id == 1 && k == 0 && m_rd[k] < 8) check("t1_byte", txd[k], lit1[m_rd[k]]);
              if (test_id == 2 && k == 0 && m_rd[k] < 4) check("t2_byte", txd[k], lit2[m_rd[k]]);
              m_rd[k]++;
              m_last[k] = m_cyc[k];
              if (m_rd[k] % NB != 0) m_due[k] = m_cyc[k] + 1;
              else                   m_due[k] = m_cyc[k] + 3;
            end
          end
        end
      end else begin
        check("idle_busy",  busy[k],  1'b0);
        check("idle_sel",   sel[k],   1'b0);
        check("idle_valid", valid[k], 1'b0);
        check("idle_done",  done[k],  1'b0);
        if (start[k] && !rst[k]) begin
          for (int r = 0; r < n; r++)
            for (int b = 0; b < NB; b++)
              exp_mem[k][r*NB + b] = bank[k][r][WW-1-8*b -: 8];
          m_wr[k]     = n * NB;
          m_rd[k]     = 0;
          m_cyc[k]    = 0;
          m_last[k]   = -10;
          m_due[k]    = 2;
          m_active[k] = 1'b1;
        end
      end

      if (rst[k]) m_active[k] = 1'b0;
      m_rst_prev[k] = rst[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      case (mode[k])
        M_ONES:  ready[k] = 1'b1;
        M_TOG:   ready[k] = ~ready[k];
        M_RAND:  ready[k] = 1'($urandom_range(0, 1));
        default: ready[k] = 1'b0;
      endcase
    end
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input string name);
    int t;
    t = 0;
    while (!done[k] && t < 3000) begin
      tick();
      t++;
    end
    if (!done[k]) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no done within 3000 cycles", name);
    end
    tick();
  endtask

  task automatic wait_cond0(input int sel_cond, input string name);
    int t;
    bit hit;
    t = 0;
    hit = 1'b0;
    while (!hit && t < 3000) begin
      case (sel_cond)
        0:       hit = busy[0] && addr[0] == 5;
        1:       hit = valid[0] && m_rd[0] == 14;
        default: hit = busy[1] && !valid[1] && addr[1] == 1;
      endcase
      if (!hit) begin
        tick();
        t++;
      end
    end
    if (!hit) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: condition not reached within 3000 cycles", name);
    end
  endtask

  initial begin
    int d0;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; ready[k] = 1'b0; mode[k] = M_ONES;
      m_active[k] = 1'b0; m_rst_prev[k] = 1'b0; n_dones[k] = 0;
      m_rd[k] = 0; m_wr[k] = 0; m_cyc[k] = 0; m_last[k] = 0; m_due[k] = 0;
    end
    for (int i = 0; i < 32; i++) begin
      bank[0][i] = 32'hA0B0C000 + i;
      bank[1][i] = $urandom;
    end
    repeat (3) tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();

    // Full dump at full rate; byte values and latency pinned literally.
    test_id = 1;
    pulse_start(0);
    wait_done(0, "t1");

    // Alternating ready; reg0 carries a recognisable pattern.
    test_id = 2;
    bank[0][0] = 32'h12345678;
    mode[0] = M_TOG;
    pulse_start(0);
    wait_done(0, "t2");

    // A second start in the middle of the dump must be ignored.
    test_id = 3;
    mode[0] = M_RAND;
    d0 = n_dones[0];
    pulse_start(0);
    wait_cond0(0, "t3_reach_reg5");
    pulse_start(0);
    wait_done(0, "t3");
    repeat (3) tick();
    check("t3_one_done", n_dones[0] - d0, 1);

    // Reset while reg3 byte2 is on the bus, then restart from reg0.
    test_id = 4;
    pulse_start(0);
    wait_cond0(1, "t4_reach_r3b2");
    check("t4_addr_before_rst", addr[0], 3);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    check("t4_valid_after_rst", valid[0], 1'b0);
    check("t4_sel_after_rst", sel[0], 1'b0);
    mode[0] = M_ONES;
    tick();
    pulse_start(0);
    wait_done(0, "t4_restart");

    // Small bank: overwrite reg1 right after it was latched.
    test_id = 5;
    pulse_start(1);
    wait_cond0(2, "t5_latch_reg1");
    tick();
    bank[1][1] = 32'hFFFFFFFF;
    wait_done(1, "t5");

    // Sink stalls for 50 cycles on the first byte.
    test_id = 6;
    mode[0] = M_ZERO;
    pulse_start(0);
    repeat (50) tick();
    check("t6_valid_held", valid[0], 1'b1);
    check("t6_data_held", txd[0], 8'h12);
    check("t6_busy_held", busy[0], 1'b1);
    check("t6_addr_held", addr[0], 0);
    mode[0] = M_ONES;
    wait_done(0, "t6");

    // Start raised during the done cycle is dropped.
    test_id = 7;
    pulse_start(1);
    while (!done[1] && m_active[1]) tick();
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    check("t7_start_in_done_busy", busy[1], 1'b0);
    tick();
    check("t7_still_idle", busy[1], 1'b0);

    // Random banks, random ready and stray start pulses on the small bank.
    test_id = 8;
    mode[1] = M_RAND;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N1; i++) bank[1][i] = $urandom;
      pulse_start(1);
      repeat ($urandom_range(1, 10)) tick();
      pulse_start(1);
      wait_done(1, "t8");
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
